cpu_control: RTL and testbench
==============================

# cpu_control

Multi-cycle control and datapath sequencer that drives the 16-bit ALU: fetches instructions over a shared memory port, decodes them, presents operands and an op code to the ALU, and consumes its result and `bcond` output to write back registers or redirect the PC. It is the initiator side of the ALU interface and sits between the memory system and the ALU in the CPU top level.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded at reset.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `mem_req`  out  1  memory request; held high until acknowledged.
- `mem_we`  out  1  1 = write (SWD), 0 = read (fetch or LWD).
- `mem_addr`  out  16  word address.
- `mem_wdata`  out  16  store data.
- `mem_rdata`  in  16  read data, valid when `mem_ack` = 1.
- `mem_ack`  in  1  transfer complete; sampled on the rising edge while `mem_req` = 1.
- `alu_a`, `alu_b`  out  16  ALU operands.
- `alu_op`  out  4  ALU op code (0 ADD … 12 BLZ).
- `alu_c`  in  16  ALU result.
- `alu_bcond`  in  1  ALU branch condition.
- `pc`  out  16  current PC.
- `halted`  out  1  HLT or illegal opcode reached.
- `illegal`  out  1  halt caused by an illegal opcode.
- `num_inst`  out  16  retired-instruction count (see Configuration).

## Operation
- Instruction format: [15:12] opcode, [11:10] rs, [9:8] rt, [7:6] rd, [5:0] func, [7:0] imm8, [11:0] jump target.
- Opcode 0 (R-type): func 0–7 → `alu_op` 0–7 (ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR). rd ← C. Func > 7 is illegal.
- Opcode 1, ADI: rt ← rs + sext(imm8), `alu_op` = 0.
- Opcode 2, ORI: rt ← rs | zext(imm8), `alu_op` = 3.
- Opcode 3, LHI: rt ← {imm8, 8'h00}, `alu_op` = 8, `alu_b` = zext(imm8).
- Opcode 4, LWD: rt ← mem[rs + sext(imm8)].
- Opcode 5, SWD: mem[rs + sext(imm8)] ← rt. Address uses `alu_op` = 0.
- Opcodes 6–9 (BNE, BEQ, BGZ, BLZ): `alu_op` = 9–12, `alu_a` = rs, `alu_b` = rt.
  - If `alu_bcond` = 1, PC ← PC+1+sext(imm8).
  - Otherwise PC ← PC+1.
- Opcode 10, JMP: PC ← {PC[15:12], target}.
- Opcode 15, HLT: enter HALT.
- Opcodes 11–14 are illegal: enter HALT and set `illegal` = 1.
- Register file: 4 × 16 bits, reset to 0, no hardwired zero register.
- FSM states: IF → ID → EX → {MEM} → {WB} → IF, plus HALT.
  - IF: `mem_req` = 1, `mem_addr` = PC, wait for `mem_ack`, latch IR.
  - ID: read registers. JMP, HLT and illegal opcodes resolve here.
  - EX: drive the ALU. Branches update the PC here and return to IF.
  - MEM: LWD/SWD transfer, wait for `mem_ack`. SWD then returns to IF.
  - WB: register write, then IF.
- Non-branch instructions update PC ← PC+1 on completion.
- All PC arithmetic is modulo 2^16 (16'hFFFF + 1 = 0).
- HALT is terminal until reset. `mem_req` = 0 in HALT.
- Outside EX/MEM, `alu_op` = 0 and `alu_a` = `alu_b` = 0.

## Timing
- All outputs are registered.
- Reset values: `pc` = `RESET_PC`. `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `alu_a`, `alu_b`, `alu_op`, `halted`, `illegal` and `num_inst` are 0.
- Reset takes effect immediately, including mid-transaction: `mem_req` drops asynchronously and state returns to IF.
- An acknowledged transaction may complete in the cycle it is requested (ack in the same cycle as req).
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` = 1.
- Cycle counts with zero-wait memory:
  - R-type, ADI, ORI, LHI: 4 cycles.
  - Branch: 3 cycles.
  - SWD: 4 cycles.
  - LWD: 5 cycles.
  - JMP: 2 cycles.
- Each `mem_ack` wait cycle adds one cycle to the state that is waiting.
- `alu_c` and `alu_bcond` are sampled at the end of EX (combinational ALU, one-cycle budget).
- A WB write is visible to the next instruction's ID. There are no hazards because execution is strictly sequential.
- `mem_ack` while `mem_req` = 0 is ignored.

## Configuration
- `CPU_CTRL_PERF_EN` defined: `num_inst` increments by 1, wrapping at 2^16, in the cycle each instruction retires.
  - HLT counts as retired.
  - Illegal opcodes do not count.
- `CPU_CTRL_PERF_EN` not defined: `num_inst` is tied to 0 and no counter logic is built.

## Structure
- `cpu_pkg` holds:
  - instruction opcode and R-type func constants;
  - ALU op-code constants 0–12;
  - the FSM state enum;
  - field-position constants for rs, rt, rd and imm8.
- One sub-module, `reg_file`: 4 × 16 bits, two asynchronous read ports, one synchronous write port, async active-low reset.

## Test plan
- ADI r1 ← r0+5, then ADD r2 ← r1+r1 → r2 = 16'h000A, and the ADD takes 4 cycles with zero-wait memory.
- LHI r3 = 8'h12, then ORI r3 |= 8'h34 → r3 = 16'h1234. SWD to address 8, then LWD into r0 → r0 = 16'h1234.
- BEQ with r0 = r1 at PC = 16'h0010, imm8 = 8'hFE → PC = 16'h000F. The same branch with r0 ≠ r1 → PC = 16'h0011.
- `mem_ack` delayed 3 cycles during IF → `mem_req` and `mem_addr` stay constant, and the instruction completes 3 cycles later.
- Opcode 12 → `halted` = 1, `illegal` = 1, `mem_req` stays 0. Reset asserted mid-LWD → all outputs return to reset values immediately.
- With `CPU_CTRL_PERF_EN`, run 5 instructions ending in HLT → `num_inst` = 5. Without it → `num_inst` = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_control sequencer: opcodes, R-type funcs, ALU ops,
// instruction field positions and the FSM state type.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADI   = 4'd1;
  localparam logic [3:0] OP_ORI   = 4'd2;
  localparam logic [3:0] OP_LHI   = 4'd3;
  localparam logic [3:0] OP_LWD   = 4'd4;
  localparam logic [3:0] OP_SWD   = 4'd5;
  localparam logic [3:0] OP_BNE   = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BGZ   = 4'd8;
  localparam logic [3:0] OP_BLZ   = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_HLT   = 4'd15;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BGZ = 4'd11;
  localparam logic [3:0] ALU_BLZ = 4'd12;

  localparam int unsigned RS_MSB   = 11;
  localparam int unsigned RS_LSB   = 10;
  localparam int unsigned RT_MSB   = 9;
  localparam int unsigned RT_LSB   = 8;
  localparam int unsigned RD_MSB   = 7;
  localparam int unsigned RD_LSB   = 6;
  localparam int unsigned IMM8_MSB = 7;
  localparam int unsigned IMM8_LSB = 0;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_control_reg_file.sv
// 4 x 16-bit register file: two asynchronous read ports, one synchronous write port.
module reg_file
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  ra_addr_i,
  output logic [15:0] ra_data_o,
  input  logic [1:0]  rb_addr_i,
  output logic [15:0] rb_data_o,
  input  logic        we_i,
  input  logic [1:0]  wa_i,
  input  logic [15:0] wd_i
);

  logic [15:0] regs_q [4];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving an external 16-bit ALU.
// Optional retired-instruction counter enabled by CPU_CTRL_PERF_EN.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_c,
  input  logic        alu_bcond,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] num_inst
);

  state_e      state_q;
  logic [15:0] pc_q, ir_q, wb_data_q;
  logic [15:0] mem_addr_q, mem_wdata_q, alu_a_q, alu_b_q;
  logic        mem_req_q, mem_we_q, halted_q, illegal_q;
  logic [3:0]  alu_op_q;

  logic [3:0]  opcode;
  logic [1:0]  rs, rt, rd, wa;
  logic [5:0]  func;
  logic [7:0]  imm8;
  logic [15:0] imm_sext, imm_zext, rs_val, rt_val;
  logic [15:0] pc_inc, br_next, jmp_target;
  logic        is_branch, is_mem, rf_we;

  assign opcode     = ir_q[15:12];
  assign rs         = ir_q[RS_MSB:RS_LSB];
  assign rt         = ir_q[RT_MSB:RT_LSB];
  assign rd         = ir_q[RD_MSB:RD_LSB];
  assign func       = ir_q[5:0];
  assign imm8       = ir_q[IMM8_MSB:IMM8_LSB];
  assign imm_sext   = sext8(imm8);
  assign imm_zext   = {8'h00, imm8};
  assign pc_inc     = pc_q + 16'd1;
  assign br_next    = alu_bcond ? (pc_inc + imm_sext) : pc_inc;
  assign jmp_target = {pc_q[15:12], ir_q[11:0]};
  assign is_branch  = (opcode inside {OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ});
  assign is_mem     = (opcode == OP_LWD) || (opcode == OP_SWD);
  assign wa         = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_we      = (state_q == S_WB);

  reg_file u_rf (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .ra_addr_i (rs),
    .ra_data_o (rs_val),
    .rb_addr_i (rt),
    .rb_data_o (rt_val),
    .we_i      (rf_we),
    .wa_i      (wa),
    .wd_i      (wb_data_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IF;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      wb_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        // Only the first fetch after reset needs this extra request cycle;
        // every other path into IF raises the request on the way in.
        S_IF: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_ID;
          end
        end
        S_ID: begin
          case (opcode)
            OP_RTYPE: begin
              if (func > FUNC_SHR) begin
                halted_q  <= 1'b1;
                illegal_q <= 1'b1;
                state_q   <= S_HALT;
              end else begin
                alu_a_q  <= rs_val;
                alu_b_q  <= rt_val;
                alu_op_q <= func[3:0];
                state_q  <= S_EX;
              end
            end
            OP_ADI, OP_LWD, OP_SWD: begin
              alu_a_q  <= rs_val;
              alu_b_q  <= imm_sext;
              alu_op_q <= ALU_ADD;
              state_q  <= S_EX;
            end
            OP_ORI: begin
              alu_a_q  <= rs_val;
              alu_b_q  <= imm_zext;
              alu_op_q <= ALU_ORR;
              state_q  <= S_EX;
            end
            OP_LHI: begin
              alu_a_q  <= '0;
              alu_b_q  <= imm_zext;
              alu_op_q <= ALU_LHI;
              state_q  <= S_EX;
            end
            // Branch opcodes 6..9 map onto ALU ops 9..12 in order.
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
              alu_a_q  <= rs_val;
              alu_b_q  <= rt_val;
              alu_op_q <= opcode + 4'd3;
              state_q  <= S_EX;
            end
            OP_JMP: begin
              pc_q       <= jmp_target;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= jmp_target;
              state_q    <= S_IF;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= S_HALT;
            end
          endcase
        end
        S_EX: begin
          if (is_mem) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (opcode == OP_SWD);
            mem_addr_q  <= alu_c;
            mem_wdata_q <= rt_val;
            state_q     <= S_MEM;
          end else begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            if (is_branch) begin
              pc_q       <= br_next;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= br_next;
              state_q    <= S_IF;
            end else begin
              wb_data_q <= alu_c;
              state_q   <= S_WB;
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            mem_we_q <= 1'b0;
            if (opcode == OP_LWD) begin
              wb_data_q <= mem_rdata;
              mem_req_q <= 1'b0;
              state_q   <= S_WB;
            end else begin
              pc_q       <= pc_inc;
              mem_addr_q <= pc_inc;
              state_q    <= S_IF;
            end
          end
        end
        S_WB: begin
          pc_q       <= pc_inc;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_inc;
          state_q    <= S_IF;
        end
        S_HALT: ;
        default: state_q <= S_HALT;
      endcase
    end
  end

`ifdef CPU_CTRL_PERF_EN
  logic        retire;
  logic [15:0] num_inst_q;

  always_comb begin
    retire = (state_q == S_WB)
          || (state_q == S_EX  && is_branch)
          || (state_q == S_MEM && mem_ack && opcode == OP_SWD)
          || (state_q == S_ID  && (opcode == OP_JMP || opcode == OP_HLT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    num_inst_q <= '0;
    else if (retire) num_inst_q <= num_inst_q + 16'd1;
  end

  assign num_inst = num_inst_q;
`else
  assign num_inst = '0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: memory responder with programmable ack delay,
// behavioural ALU, and per-scenario tasks with hand-computed expectations.
module tb_cpu_control;

  logic        clk, reset_n;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_bcond;
  logic [15:0] pc, num_inst;
  logic        halted, illegal;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wcnt = 0;
  int fcyc[$];
  logic [15:0] faddr[$];
  logic [15:0] rom  [256];
  logic [15:0] dmem [256];
  bit          dvalid [256];

`ifdef CPU_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  cpu_control #(.RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_bcond (alu_bcond),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal),
    .num_inst  (num_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU
  always_comb begin
    alu_c     = '0;
    alu_bcond = 1'b0;
    case (alu_op)
      4'd0:  alu_c = alu_a + alu_b;
      4'd1:  alu_c = alu_a - alu_b;
      4'd2:  alu_c = alu_a & alu_b;
      4'd3:  alu_c = alu_a | alu_b;
      4'd4:  alu_c = ~alu_a;
      4'd5:  alu_c = ~alu_a + 16'd1;
      4'd6:  alu_c = alu_a << 1;
      4'd7:  alu_c = alu_a >> 1;
      4'd8:  alu_c = {alu_b[7:0], 8'h00};
      4'd9:  alu_bcond = (alu_a != alu_b);
      4'd10: alu_bcond = (alu_a == alu_b);
      4'd11: alu_bcond = ($signed(alu_a) > 16'sd0);
      4'd12: alu_bcond = ($signed(alu_a) < 16'sd0);
      default: ;
    endcase
  end

  // Memory responder: ack after ack_delay wait cycles; logs instruction fetches.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      wcnt    = 0;
      for (int i = 0; i < 256; i++) dvalid[i] = 1'b0;
      fcyc.delete();
      faddr.delete();
    end else if (mem_req) begin
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_we) begin
          dmem[mem_addr[7:0]]   = mem_wdata;
          dvalid[mem_addr[7:0]] = 1'b1;
        end else begin
          mem_rdata = dvalid[mem_addr[7:0]] ? dmem[mem_addr[7:0]] : rom[mem_addr[7:0]];
          if (mem_addr == pc) begin
            fcyc.push_back(cyc);
            faddr.push_back(mem_addr);
          end
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  function automatic int fc(input int i);
    return (i < fcyc.size()) ? fcyc[i] : -1000;
  endfunction

  function automatic logic [15:0] fa(input int i);
    return (i < faddr.size()) ? faddr[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] dm(input int a);
    return dvalid[a] ? dmem[a] : 16'hxxxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL %s_halt_timeout: halted=%b, required 1", name, halted);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({mem_req, mem_we, halted, illegal} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: req/we/halted/illegal=%b, required 0000", {mem_req, mem_we, halted, illegal});
    end
    tests++;
    if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h, required 0000", pc); end
    tests++;
    if ({mem_addr, mem_wdata, alu_a, alu_b, alu_op, num_inst} !== '0) begin
      fails++;
      $display("FAIL reset_buses: addr=%h wdata=%h a=%h b=%h op=%h n=%h, required all 0",
               mem_addr, mem_wdata, alu_a, alu_b, alu_op, num_inst);
    end
    release_reset();
    wait_halt("reset_hlt");
    tests++;
    if (fa(0) !== 16'h0000) begin fails++; $display("FAIL reset_first_fetch: got %h, required 0000", fa(0)); end
    tests++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL reset_hlt_illegal: got %b, required 0", illegal); end
  endtask

  task automatic test_alu_ops();
    do_reset();
    rom[0] = 16'h1105;  // ADI r1 = r0 + 5
    rom[1] = 16'h0580;  // ADD r2 = r1 + r1
    rom[2] = 16'h5208;  // SWD r2 -> [r0+8]
    rom[3] = 16'h5109;  // SWD r1 -> [r0+9]
    rom[4] = 16'hF000;  // HLT
    release_reset();
    wait_halt("alu");
    tests++;
    if (dm(8) !== 16'h000A) begin fails++; $display("FAIL add_result: got %h, required 000a", dm(8)); end
    tests++;
    if (dm(9) !== 16'h0005) begin fails++; $display("FAIL adi_result: got %h, required 0005", dm(9)); end
    tests++;
    if (fc(1) - fc(0) !== 4) begin fails++; $display("FAIL adi_cycles: got %0d, required 4", fc(1) - fc(0)); end
    tests++;
    if (fc(2) - fc(1) !== 4) begin fails++; $display("FAIL add_cycles: got %0d, required 4", fc(2) - fc(1)); end
    tests++;
    if (fc(3) - fc(2) !== 4) begin fails++; $display("FAIL swd_cycles: got %0d, required 4", fc(3) - fc(2)); end
    tests++;
    if (num_inst !== ((PERF != 0) ? 16'd5 : 16'd0)) begin
      fails++;
      $display("FAIL num_inst: got %0d, required %0d", num_inst, (PERF != 0) ? 5 : 0);
    end
    tests++;
    if ({illegal, mem_req, alu_op} !== 6'b0) begin
      fails++;
      $display("FAIL hlt_outputs: illegal=%b req=%b op=%h, required 0 0 0", illegal, mem_req, alu_op);
    end
  endtask

  task automatic test_lhi_mem();
    do_reset();
    rom[0] = 16'h3312;  // LHI r3 = 12_00
    rom[1] = 16'h2F34;  // ORI r3 |= 34
    rom[2] = 16'h5308;  // SWD r3 -> [r0+8]
    rom[3] = 16'h4408;  // LWD r0 <- [r1+8]
    rom[4] = 16'h5409;  // SWD r0 -> [r1+9]
    rom[5] = 16'h0086;  // SHL r2 = r0 << 1
    rom[6] = 16'h560A;  // SWD r2 -> [r1+10]
    rom[7] = 16'hF000;
    release_reset();
    wait_halt("lhi_mem");
    tests++;
    if (dm(8) !== 16'h1234) begin fails++; $display("FAIL lhi_ori_store: got %h, required 1234", dm(8)); end
    tests++;
    if (dm(9) !== 16'h1234) begin fails++; $display("FAIL lwd_r0: got %h, required 1234", dm(9)); end
    tests++;
    if (dm(10) !== 16'h2468) begin fails++; $display("FAIL shl_result: got %h, required 2468", dm(10)); end
    tests++;
    if (fc(1) - fc(0) !== 4) begin fails++; $display("FAIL lhi_cycles: got %0d, required 4", fc(1) - fc(0)); end
    tests++;
    if (fc(4) - fc(3) !== 5) begin fails++; $display("FAIL lwd_cycles: got %0d, required 5", fc(4) - fc(3)); end
  endtask

  task automatic test_branch();
    // taken: JMP 0x010, BEQ r0==r1 with imm -2 -> 0x000F
    do_reset();
    rom[8'h00] = 16'hA010;
    rom[8'h10] = 16'h71FE;
    release_reset();
    wait_halt("beq_taken");
    tests++;
    if (fa(1) !== 16'h0010) begin fails++; $display("FAIL jmp_target: got %h, required 0010", fa(1)); end
    tests++;
    if (fc(1) - fc(0) !== 2) begin fails++; $display("FAIL jmp_cycles: got %0d, required 2", fc(1) - fc(0)); end
    tests++;
    if (fa(2) !== 16'h000F) begin fails++; $display("FAIL beq_taken_pc: got %h, required 000f", fa(2)); end
    tests++;
    if (fc(2) - fc(1) !== 3) begin fails++; $display("FAIL branch_cycles: got %0d, required 3", fc(2) - fc(1)); end
    // not taken: r0 = 1 first
    do_reset();
    rom[8'h00] = 16'h1001;
    rom[8'h01] = 16'hA010;
    rom[8'h10] = 16'h71FE;
    release_reset();
    wait_halt("beq_not_taken");
    tests++;
    if (fa(3) !== 16'h0011) begin fails++; $display("FAIL beq_not_taken_pc: got %h, required 0011", fa(3)); end
    // backward branch from 0 wraps to 0xFFFF
    do_reset();
    rom[8'h00] = 16'h71FE;
    release_reset();
    wait_halt("beq_wrap");
    tests++;
    if (fa(1) !== 16'hFFFF) begin fails++; $display("FAIL pc_wrap: got %h, required ffff", fa(1)); end
  endtask

  task automatic test_ack_delay();
    int n;
    int bad;
    logic [15:0] a0;
    do_reset();
    rom[0] = 16'h1105;  // ADI r1 = 5
    rom[1] = 16'h5108;  // SWD r1 -> [r0+8]
    ack_delay = 3;
    release_reset();
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    a0  = mem_addr;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== a0 || mem_we !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0 || a0 !== 16'h0000) begin
      fails++;
      $display("FAIL ack_wait_stable: unstable cycles=%0d first addr=%h, required 0 and 0000", bad, a0);
    end
    wait_halt("ack_delay");
    tests++;
    if (dm(8) !== 16'h0005) begin fails++; $display("FAIL delayed_store: got %h, required 0005", dm(8)); end
    tests++;
    if (fc(1) - fc(0) !== 7) begin fails++; $display("FAIL delayed_adi_cycles: got %0d, required 7", fc(1) - fc(0)); end
    tests++;
    if (fc(2) - fc(1) !== 10) begin fails++; $display("FAIL delayed_swd_cycles: got %0d, required 10", fc(2) - fc(1)); end
  endtask

  task automatic test_illegal();
    int bad;
    do_reset();
    rom[0] = 16'hC000;
    release_reset();
    wait_halt("illegal_op12");
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    tests++;
    if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_op12: got %b, required 1", illegal); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL halt_terminal: bad cycles=%0d, required 0", bad); end
    tests++;
    if ({num_inst, alu_a, alu_b, alu_op} !== '0) begin
      fails++;
      $display("FAIL illegal_quiet: n=%h a=%h b=%h op=%h, required 0", num_inst, alu_a, alu_b, alu_op);
    end
    do_reset();
    rom[0] = 16'h0008;  // R-type func 8
    release_reset();
    wait_halt("illegal_func");
    tests++;
    if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_func8: got %b, required 1", illegal); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    rom[0] = 16'h4008;  // LWD r0 <- [r0+8]
    ack_delay = 5;
    release_reset();
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === 16'h0008) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0008 || alu_b !== 16'h0008) begin
      fails++;
      $display("FAIL mid_lwd_reached: req=%b addr=%h b=%h, required 1 0008 0008", mem_req, mem_addr, alu_b);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL async_req_drop: got %b, required 0", mem_req); end
    tests++;
    if ({pc, mem_addr, mem_wdata, alu_a, alu_b, alu_op, mem_we, halted, illegal, num_inst} !== '0) begin
      fails++;
      $display("FAIL async_reset_outputs: pc=%h addr=%h b=%h op=%h we=%b, required all 0",
               pc, mem_addr, alu_b, alu_op, mem_we);
    end
    ack_delay = 0;
    release_reset();
    wait_halt("after_mid_reset");
    tests++;
    if (fa(0) !== 16'h0000) begin fails++; $display("FAIL restart_fetch: got %h, required 0000", fa(0)); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_alu_ops();
    test_lhi_mem();
    test_branch();
    test_ack_delay();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
